// File: rtl/dna_reader.sv
// Reads the device DNA serial port once after reset and again on each start request
// issued once a read has completed. dna_value/dna_valid hold the last completed word.
module dna_reader #(
    parameter int DW  = 57,
    parameter int DIV = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          dna_dout,
    output logic          dna_clk,
    output logic          dna_read,
    output logic          dna_shift,
    output logic [DW-1:0] dna_value,
    output logic          dna_valid,
    output logic          busy
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = $clog2(DW + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t          state_q, state_d;
    logic            pending_q, pending_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            phase_q, phase_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DW-1:0]   sreg_q, sreg_d;
    logic [DW-1:0]   value_q, value_d;
    logic            valid_q, valid_d;
    logic            dna_clk_q, dna_clk_d;
    logic            dna_read_q, dna_read_d;
    logic            dna_shift_q, dna_shift_d;
    logic            tick;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        sreg_d    = sreg_q;
        value_d   = value_q;
        valid_d   = valid_q;
        tick      = (cnt_q == CNT_MAX);

        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                phase_d = 1'b0;
                if (pending_q) begin
                    state_d   = LOAD;
                    pending_d = 1'b0;
                    bit_cnt_d = '0;
                end else if (start) begin
                    pending_d = 1'b1;
                end
            end
            LOAD: begin
                if (tick) begin
                    cnt_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        state_d = SHIFT;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SHIFT: begin
                if (tick) begin
                    cnt_d = '0;
                    if (!phase_q) begin
                        sreg_d    = {sreg_q[DW-2:0], dna_dout};
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        // Last bit: finish on the low phase, no trailing dna_clk pulse.
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = DONE;
                            value_d = sreg_d;
                            valid_d = 1'b1;
                        end else begin
                            phase_d = 1'b1;
                        end
                    end else begin
                        phase_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                cnt_d   = '0;
                phase_d = 1'b0;
                if (start) begin
                    state_d   = LOAD;
                    valid_d   = 1'b0;
                    bit_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Port strobes are registered from the next-state view so they align with the FSM.
        dna_read_d  = (state_d == LOAD);
        dna_shift_d = (state_d == SHIFT);
        dna_clk_d   = ((state_d == LOAD) || (state_d == SHIFT)) && phase_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pending_q   <= 1'b1;
            cnt_q       <= '0;
            phase_q     <= 1'b0;
            bit_cnt_q   <= '0;
            value_q     <= '0;
            valid_q     <= 1'b0;
            dna_clk_q   <= 1'b0;
            dna_read_q  <= 1'b0;
            dna_shift_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            bit_cnt_q   <= bit_cnt_d;
            value_q     <= value_d;
            valid_q     <= valid_d;
            dna_clk_q   <= dna_clk_d;
            dna_read_q  <= dna_read_d;
            dna_shift_q <= dna_shift_d;
        end
    end

    always_ff @(posedge clk) begin
        sreg_q <= sreg_d;
    end

    assign dna_clk   = dna_clk_q;
    assign dna_read  = dna_read_q;
    assign dna_shift = dna_shift_q;
    assign dna_value = value_q;
    assign dna_valid = valid_q;
    assign busy      = (state_q == LOAD) || (state_q == SHIFT);
endmodule

// File: tb/tb_dna_reader.sv
// Directed bench for dna_reader: default instance plus a DW=8/DIV=1 instance,
// each driven by a behavioural DNA port model.
module tb_dna_reader;
    localparam logic [56:0] VAL_A = 57'h0823456789ABCDE;
    localparam logic [56:0] VAL_1 = 57'h1FFFFFFFFFFFFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Default instance
    logic        rst = 1'b1, start = 1'b0;
    logic        a_dout, a_clk, a_read, a_shift, a_valid, a_busy;
    logic [56:0] a_value;
    logic [56:0] model_a_val = VAL_A;
    logic [56:0] model_a_sr  = '0;

    dna_reader dut_a (
        .clk(clk), .rst(rst), .start(start), .dna_dout(a_dout),
        .dna_clk(a_clk), .dna_read(a_read), .dna_shift(a_shift),
        .dna_value(a_value), .dna_valid(a_valid), .busy(a_busy)
    );

    always @(posedge a_clk) begin
        if (a_read)       model_a_sr <= model_a_val;
        else if (a_shift) model_a_sr <= {model_a_sr[55:0], 1'b0};
    end
    assign a_dout = model_a_sr[56];

    // Small instance
    logic       rst_b = 1'b1, start_b = 1'b0;
    logic       b_dout, b_clk, b_read, b_shift, b_valid, b_busy;
    logic [7:0] b_value;
    logic [7:0] model_b_val = 8'hA5;
    logic [7:0] model_b_sr  = '0;

    dna_reader #(.DW(8), .DIV(1)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .dna_dout(b_dout),
        .dna_clk(b_clk), .dna_read(b_read), .dna_shift(b_shift),
        .dna_value(b_value), .dna_valid(b_valid), .busy(b_busy)
    );

    always @(posedge b_clk) begin
        if (b_read)       model_b_sr <= model_b_val;
        else if (b_shift) model_b_sr <= {model_b_sr[6:0], 1'b0};
    end
    assign b_dout = model_b_sr[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst_b = 1'b1;
        repeat (3) step();
        n_tests++;
        if ({a_clk, a_read, a_shift, a_valid, a_busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_a_ctrl: got %b expected 00000", {a_clk, a_read, a_shift, a_valid, a_busy});
        end
        n_tests++;
        if (a_value !== 57'h0) begin
            n_fail++;
            $display("FAIL reset_a_value: got %h expected 0", a_value);
        end
        n_tests++;
        if ({b_clk, b_read, b_shift, b_valid, b_busy, b_value} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_b: got %h expected 0", {b_clk, b_read, b_shift, b_valid, b_busy, b_value});
        end
    endtask

    task automatic test_first_read();
        int n_read = 0, rise_read = 0, rise_shift = 0;
        logic prev_clk = 1'b0;
        rst = 1'b0;
        for (int i = 1; i <= 461; i++) begin
            step();
            if (a_read) n_read++;
            if (!prev_clk && a_clk && a_read)  rise_read++;
            if (!prev_clk && a_clk && a_shift) rise_shift++;
            prev_clk = a_clk;
            if (i == 1) begin
                n_tests++;
                if ({a_read, a_busy, a_clk} !== 3'b110) begin
                    n_fail++;
                    $display("FAIL first_load_entry: got %b expected 110", {a_read, a_busy, a_clk});
                end
            end
            if (i == 460) begin
                n_tests++;
                if ({a_valid, a_busy} !== 2'b01) begin
                    n_fail++;
                    $display("FAIL first_pre_done: got %b expected 01", {a_valid, a_busy});
                end
            end
        end
        n_tests++;
        if ({a_valid, a_busy, a_clk, a_shift} !== 4'b1000) begin
            n_fail++;
            $display("FAIL first_done_flags: got %b expected 1000", {a_valid, a_busy, a_clk, a_shift});
        end
        n_tests++;
        if (a_value !== VAL_A) begin
            n_fail++;
            $display("FAIL first_value: got %h expected %h", a_value, VAL_A);
        end
        n_tests++;
        if (n_read !== 8 || rise_read !== 1) begin
            n_fail++;
            $display("FAIL load_protocol: got read=%0d rises=%0d expected read=8 rises=1", n_read, rise_read);
        end
        n_tests++;
        if (rise_shift !== 56) begin
            n_fail++;
            $display("FAIL shift_rises: got %0d expected 56", rise_shift);
        end
    endtask

    task automatic test_small();
        rst_b = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            step();
            if (i == 17) begin
                n_tests++;
                if (b_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL small_early: got valid=%b expected 0", b_valid);
                end
            end
        end
        n_tests++;
        if ({b_valid, b_busy, b_value} !== {2'b10, 8'hA5}) begin
            n_fail++;
            $display("FAIL small_done: got valid=%b busy=%b value=%h expected 1 0 a5", b_valid, b_busy, b_value);
        end
    endtask

    task automatic test_restart();
        model_a_val = VAL_1;
        start = 1'b1;
        step();
        start = 1'b0;
        n_tests++;
        if ({a_valid, a_busy} !== 2'b01 || a_value !== VAL_A) begin
            n_fail++;
            $display("FAIL restart_entry: got valid=%b busy=%b value=%h expected 0 1 %h", a_valid, a_busy, a_value, VAL_A);
        end
        for (int i = 2; i <= 461; i++) begin
            step();
            if (i == 460) begin
                n_tests++;
                if (a_valid !== 1'b0 || a_value !== VAL_A) begin
                    n_fail++;
                    $display("FAIL restart_hold: got valid=%b value=%h expected 0 %h", a_valid, a_value, VAL_A);
                end
            end
        end
        n_tests++;
        if ({a_valid, a_busy} !== 2'b10 || a_value !== VAL_1) begin
            n_fail++;
            $display("FAIL restart_done: got valid=%b busy=%b value=%h expected 1 0 %h", a_valid, a_busy, a_value, VAL_1);
        end
    endtask

    task automatic test_rst_abort();
        model_a_val = VAL_A;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 2; i <= 200; i++) step();
        rst = 1'b1;
        step();
        n_tests++;
        if ({a_clk, a_read, a_shift, a_valid, a_busy} !== 5'b0 || a_value !== 57'h0) begin
            n_fail++;
            $display("FAIL abort_outputs: got ctrl=%b value=%h expected 00000 0",
                     {a_clk, a_read, a_shift, a_valid, a_busy}, a_value);
        end
        step();
        rst = 1'b0;
        for (int i = 1; i <= 461; i++) begin
            step();
            if (i == 460) begin
                n_tests++;
                if (a_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort_early: got valid=%b expected 0", a_valid);
                end
            end
        end
        n_tests++;
        if (a_valid !== 1'b1 || a_value !== VAL_A) begin
            n_fail++;
            $display("FAIL abort_done: got valid=%b value=%h expected 1 %h", a_valid, a_value, VAL_A);
        end
    endtask

    task automatic test_start_ignored();
        int busy_after = 0;
        model_a_val = VAL_1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 1; i <= 700; i++) begin
            step();
            // Sampled at edges 5, 100, 300 and the DONE-entry edge 461.
            start = (i == 4 || i == 99 || i == 299 || i == 460);
            if (i == 460) begin
                n_tests++;
                if (a_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ignore_early: got valid=%b expected 0", a_valid);
                end
            end
            if (i == 461) begin
                n_tests++;
                if (a_valid !== 1'b1 || a_value !== VAL_1) begin
                    n_fail++;
                    $display("FAIL ignore_done: got valid=%b value=%h expected 1 %h", a_valid, a_value, VAL_1);
                end
            end
            if (i > 461 && a_busy) busy_after++;
        end
        start = 1'b0;
        n_tests++;
        if (busy_after !== 0 || a_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL ignore_no_reread: got busy_cycles=%0d valid=%b expected 0 1", busy_after, a_valid);
        end
    endtask

    initial begin
        test_reset();
        test_first_read();
        test_small();
        test_restart();
        test_rst_abort();
        test_start_ignored();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dna_reader.md
DNA_READER -- requirements
Module: dna_reader

Interface
REQ-001 Parameter DW, default 57, DNA width in bits; SHALL be legal for DW >= 2.
REQ-002 Parameter DIV, default 4, clk cycles per dna_clk half-period; SHALL be legal for DIV >= 1.
REQ-003 clk  in  1  system clock; all logic is in this single clock domain.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  single-cycle request to re-read DNA.
REQ-006 dna_dout  in  1  serial data from the device DNA port.
REQ-007 dna_clk  out  1  DNA port clock, generated from clk.
REQ-008 dna_read  out  1  DNA port load strobe.
REQ-009 dna_shift  out  1  DNA port shift enable.
REQ-010 dna_value  out  DW  last completed DNA word, MSB first as received.
REQ-011 dna_valid  out  1  dna_value holds a completed read.
REQ-012 busy  out  1  read sequence in progress.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, SHIFT and DONE.
REQ-014 A pending flag SHALL be set by reset, so that a read starts automatically after reset.
REQ-015 IDLE with pending set SHALL go to LOAD on the next cycle and clear pending.
REQ-016 A divider counter SHALL run from 0 to DIV-1 in LOAD and SHIFT; "tick" means counter == DIV-1.
REQ-017 The counter SHALL be held at 0 in IDLE and DONE.
REQ-018 In LOAD, dna_read SHALL be 1 and dna_clk SHALL be low for DIV cycles, then high for DIV cycles.
REQ-019 LOAD SHALL then go to SHIFT with dna_clk low, so LOAD lasts exactly 2*DIV cycles.
REQ-020 In SHIFT, dna_shift SHALL be 1 and each bit SHALL use DIV low cycles followed by DIV high cycles.
REQ-021 On the tick of each low phase, the block SHALL shift dna_dout into an internal register: sreg <= {sreg[DW-2:0], dna_dout}.
REQ-022 On the same tick, the block SHALL increment the bit counter (width clog2(DW+1)).
REQ-023 On the tick that captures bit number DW, the FSM SHALL go to DONE without a following high phase.
REQ-024 In that transition, the last bit SHALL be included in the value copied to dna_value.
REQ-025 On DONE entry, dna_value SHALL be loaded from the completed shift and dna_valid SHALL go to 1.
REQ-026 dna_value SHALL not change at any other time except reset.
REQ-027 dna_clk, dna_read and dna_shift SHALL be registered outputs, and SHALL be 0 in IDLE and DONE.
REQ-028 busy SHALL be 1 exactly while the state is LOAD or SHIFT.
REQ-029 Latency: dna_valid SHALL first read 1 at cycle 1 + DIV*(2*DW+1) after the first clk edge with rst low (461 for the defaults).
REQ-030 start in DONE SHALL go to LOAD on the next cycle and clear dna_valid in that same cycle.
REQ-031 After start in DONE, dna_value SHALL keep its old value until the new read completes.
REQ-032 start in IDLE SHALL set pending.
REQ-033 start in LOAD or SHIFT SHALL be ignored; it SHALL not restart, extend or queue the read.
REQ-034 start coincident with the DONE-entry cycle SHALL be ignored.
REQ-035 The bit counter SHALL reset to 0 on every LOAD entry; the shift register need not be cleared.

Reset
REQ-036 While rst = 1, the state SHALL be IDLE, pending 1, and the counters 0.
REQ-037 While rst = 1, dna_clk, dna_read, dna_shift, dna_valid and busy SHALL be 0, and dna_value SHALL be all zeros.
REQ-038 rst asserted mid-LOAD or mid-SHIFT SHALL abort the read and discard partial bits.
REQ-039 After such an abort, a full read SHALL restart automatically with the REQ-029 latency from rst release.
REQ-040 rst SHALL have priority over start.

Verification
REQ-041 Default parameters, DNA model 57'h0823456789ABCDE, rst released -> dna_valid rises at cycle 461, dna_value = 57'h0823456789ABCDE, busy falls in the same cycle.
REQ-042 Protocol check: dna_read = 1 for exactly 8 cycles with one dna_clk rising edge; dna_shift = 1 with exactly 56 dna_clk rising edges; dna_dout is sampled 57 times, each sample one cycle before a rising edge or at SHIFT end.
REQ-043 DIV = 1, DW = 8, model 8'hA5 -> dna_valid at cycle 18, dna_value = 8'hA5.
REQ-044 DONE with value V, model changed to 57'h1FFFFFFFFFFFFFF, start pulse -> next cycle dna_valid = 0 and busy = 1; dna_value = V until completion; after 460 more cycles dna_value = 57'h1FFFFFFFFFFFFFF.
REQ-045 start pulsed at cycles 5, 100 and 300 during the initial read -> completion still at cycle 461 and no second read follows.
REQ-046 rst pulsed at cycle 200 -> all outputs read 0; dna_valid rises 461 cycles after rst release with the correct value.
